// File: rtl/range_count_driver.sv
// Range sequencer driving count_combs: total += f(hi) - f(lo-1) per range.
// Define RANGE_TIMEOUT_EN to bound the wait states by TIMEOUT_CYCLES.
module range_count_driver #(
    parameter int DATA_WIDTH     = 16,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  range_valid,
    output logic                  range_ready,
    input  logic [DATA_WIDTH-1:0] range_lo,
    input  logic [DATA_WIDTH-1:0] range_hi,
    input  logic                  range_last,
    output logic                  cc_reset,
    output logic [DATA_WIDTH-1:0] cc_n,
    input  logic                  cc_valid,
    input  logic [DATA_WIDTH-1:0] cc_count,
    output logic                  total_valid,
    input  logic                  total_ready,
    output logic [DATA_WIDTH-1:0] total_out,
    output logic                  err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR_HI,
        S_WAIT_HI,
        S_CLR_LO,
        S_WAIT_LO,
        S_ACC,
        S_NEXT,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic                  live_q;
    logic                  last_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] lo_q, hi_q;
    logic [DATA_WIDTH-1:0] hi_val_q, lo_val_q;
    logic [DATA_WIDTH-1:0] total_q;
    logic [DATA_WIDTH-1:0] lo_m1;
    logic                  take;
    logic                  bad_range;
    logic                  in_wait;
    logic                  tmo_hit;

    assign lo_m1     = lo_q - DATA_WIDTH'(1);
    assign take      = (state_q == S_IDLE) && range_valid && live_q;
    assign bad_range = range_lo > range_hi;
    assign in_wait   = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);

`ifdef RANGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tmo_q;

    // Cleared whenever outside a wait state, so each wait starts from zero
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else if (in_wait) begin
            tmo_q <= tmo_q + TW'(1);
        end else begin
            tmo_q <= '0;
        end
    end

    assign tmo_hit = !cc_valid && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        range_ready = 1'b0;
        cc_reset    = !live_q;
        cc_n        = '0;
        total_valid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                range_ready = live_q;
                if (take) begin
                    state_d = bad_range ? S_NEXT : S_CLR_HI;
                end
            end
            S_CLR_HI: begin
                cc_reset = 1'b1;
                cc_n     = hi_q;
                state_d  = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                cc_n = hi_q;
                if (cc_valid) begin
                    state_d = (lo_q != '0) ? S_CLR_LO : S_ACC;
                end else if (tmo_hit) begin
                    state_d = S_NEXT;
                end
            end
            S_CLR_LO: begin
                cc_reset = 1'b1;
                cc_n     = lo_m1;
                state_d  = S_WAIT_LO;
            end
            S_WAIT_LO: begin
                cc_n = lo_m1;
                if (cc_valid) begin
                    state_d = S_ACC;
                end else if (tmo_hit) begin
                    state_d = S_NEXT;
                end
            end
            S_ACC: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                state_d = last_q ? S_DONE : S_IDLE;
            end
            S_DONE: begin
                total_valid = 1'b1;
                if (total_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            live_q   <= 1'b0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
            lo_q     <= '0;
            hi_q     <= '0;
            hi_val_q <= '0;
            lo_val_q <= '0;
            total_q  <= '0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            if (take) begin
                lo_q   <= range_lo;
                hi_q   <= range_hi;
                last_q <= range_last;
                if (bad_range) begin
                    err_q <= 1'b1;
                end
            end
            if ((state_q == S_WAIT_HI) && cc_valid) begin
                hi_val_q <= cc_count;
                if (lo_q == '0) begin
                    lo_val_q <= '0;
                end
            end
            if ((state_q == S_WAIT_LO) && cc_valid) begin
                lo_val_q <= cc_count;
            end
            if (in_wait && tmo_hit) begin
                err_q <= 1'b1;
            end
            if (state_q == S_ACC) begin
                total_q <= total_q + (hi_val_q - lo_val_q);
            end
            if ((state_q == S_DONE) && total_ready) begin
                total_q <= '0;
            end
        end
    end

    assign total_out = total_q;
    assign err       = err_q;

endmodule

// File: tb/tb_range_count_driver.sv
// Bench for range_count_driver with a count_combs stub f(n)=3n, latency 5.
// Define RANGE_TIMEOUT_EN to also exercise the wait timeout.
module tb_range_count_driver;

    localparam int DW = 16;

    logic          clock;
    logic          reset;
    logic          range_valid;
    logic          range_ready;
    logic [DW-1:0] range_lo;
    logic [DW-1:0] range_hi;
    logic          range_last;
    logic          cc_reset;
    logic [DW-1:0] cc_n;
    logic          cc_valid;
    logic [DW-1:0] cc_count;
    logic          total_valid;
    logic          total_ready;
    logic [DW-1:0] total_out;
    logic          err;

    range_count_driver #(
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .range_valid(range_valid),
        .range_ready(range_ready),
        .range_lo   (range_lo),
        .range_hi   (range_hi),
        .range_last (range_last),
        .cc_reset   (cc_reset),
        .cc_n       (cc_n),
        .cc_valid   (cc_valid),
        .cc_count   (cc_count),
        .total_valid(total_valid),
        .total_ready(total_ready),
        .total_out  (total_out),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // count_combs stub: valid 5 cycles after clear, held until next clear
    logic [3:0] stub_cnt;
    logic       stub_dead;

    always_ff @(posedge clock) begin
        if (cc_reset) begin
            stub_cnt <= 4'd0;
        end else if (stub_cnt < 4'd4) begin
            stub_cnt <= stub_cnt + 4'd1;
        end
    end

    assign cc_valid = !stub_dead && (stub_cnt == 4'd4);
    assign cc_count = DW'(3 * cc_n);

    int tests;
    int failed;
    int pulses;
    logic mon_en;
    logic [DW-1:0] qn[$];
    logic [DW-1:0] sbq[$];

    always @(negedge clock) begin
        if (mon_en && cc_reset) begin
            pulses++;
            qn.push_back(cc_n);
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        failed++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic send(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                        input logic last);
        int n;
        n = 0;
        range_lo    = lo;
        range_hi    = hi;
        range_last  = last;
        range_valid = 1'b1;
        while (!range_ready && n < 200) begin
            @(negedge clock);
            n++;
        end
        if (n >= 200) fail_now("send");
        @(negedge clock);
        range_valid = 1'b0;
    endtask

    task automatic wait_total(input string name, input int hold,
                              output int lat);
        int viol;
        logic stable;
        logic [DW-1:0] exp;
        lat  = 0;
        viol = 0;
        while (!total_valid && lat < 500) begin
            if (range_ready) viol++;
            @(negedge clock);
            lat++;
        end
        if (lat >= 500) begin
            fail_now(name);
        end else begin
            if (sbq.size() == 0) begin
                fail_now({name, "_sb_empty"});
                exp = '0;
            end else begin
                exp = sbq.pop_front();
            end
            check({name, "_total"}, total_out, exp);
            check({name, "_busy_ready"}, viol, 0);
            if (hold > 0) begin
                stable = 1'b1;
                repeat (hold) begin
                    @(negedge clock);
                    if (!total_valid || total_out !== exp || range_ready)
                        stable = 1'b0;
                end
                check({name, "_hold_stable"}, stable, 1);
            end
            total_ready = 1'b1;
            @(negedge clock);
            total_ready = 1'b0;
            check({name, "_valid_drop"}, total_valid, 0);
            check({name, "_cleared"}, total_out, 0);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_ready"}, range_ready, 0);
        check({name, "_cc_reset"}, cc_reset, 1);
        check({name, "_cc_n"}, cc_n, 0);
        check({name, "_tvalid"}, total_valid, 0);
        check({name, "_tout"}, total_out, 0);
        check({name, "_err"}, err, 0);
    endtask

    task automatic release_reset();
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("rel_cc_reset_held", cc_reset, 1);
        check("rel_ready_low", range_ready, 0);
        @(negedge clock);
        check("rel_ready_up", range_ready, 1);
        check("rel_cc_reset_low", cc_reset, 0);
        mon_en = 1'b1;
    endtask

    typedef struct {
        logic [DW-1:0] lo;
        logic [DW-1:0] hi;
        logic          last;
        logic [DW-1:0] exp_total;
        int            exp_pulses;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int lat;
        logic [DW-1:0] first_hi;
        logic new_batch;
        tests       = 0;
        failed      = 0;
        pulses      = 0;
        mon_en      = 1'b0;
        stub_dead   = 1'b0;
        reset       = 1'b1;
        range_valid = 1'b0;
        range_lo    = '0;
        range_hi    = '0;
        range_last  = 1'b0;
        total_ready = 1'b0;
        first_hi    = '0;

        vecs[0] = '{16'd11, 16'd22,   1'b1, 16'd36,   2, 14};
        vecs[1] = '{16'd0,  16'd5,    1'b1, 16'd15,   1, 8};
        vecs[2] = '{16'd1,  16'd4,    1'b0, 16'd0,    0, 0};
        vecs[3] = '{16'd10, 16'd10,   1'b1, 16'd15,   4, 14};
        vecs[4] = '{16'd2,  16'd2,    1'b1, 16'd3,    2, 14};
        vecs[5] = '{16'd1,  16'hFFFF, 1'b1, 16'hFFFD, 2, 14};
        vecs[6] = '{16'd0,  16'd0,    1'b1, 16'd0,    1, 8};

        repeat (2) @(negedge clock);
        check_reset_vals("rst");
        release_reset();

        new_batch = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (new_batch) begin
                pulses = 0;
                qn.delete();
                first_hi = vecs[i].hi;
            end
            send(vecs[i].lo, vecs[i].hi, vecs[i].last);
            new_batch = vecs[i].last;
            if (vecs[i].last) begin
                sbq.push_back(vecs[i].exp_total);
                wait_total($sformatf("vec%0d", i), 0, lat);
                check($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
                check($sformatf("vec%0d_pulses", i), pulses,
                      vecs[i].exp_pulses);
                if (qn.size() > 0)
                    check($sformatf("vec%0d_n_hi", i), qn[0], first_hi);
                if (vecs[i].exp_pulses == 2 && qn.size() > 1)
                    check($sformatf("vec%0d_n_lo", i), qn[1],
                          vecs[i].lo - 16'd1);
                check($sformatf("vec%0d_err", i), err, 0);
            end
        end

        // lo > hi: flagged, no query, zero contribution
        pulses = 0;
        send(16'd9, 16'd3, 1'b1);
        sbq.push_back(16'd0);
        wait_total("bad", 0, lat);
        check("bad_lat", lat, 1);
        check("bad_pulses", pulses, 0);
        check("bad_err", err, 1);
        send(16'd2, 16'd2, 1'b1);
        sbq.push_back(16'd3);
        wait_total("after_bad", 0, lat);
        check("after_bad_err_sticky", err, 1);

        // consumer backpressure
        send(16'd3, 16'd5, 1'b1);
        sbq.push_back(16'd9);
        wait_total("bp", 10, lat);
        send(16'd2, 16'd2, 1'b1);
        sbq.push_back(16'd3);
        wait_total("bp_next", 0, lat);

        // async reset in WAIT_LO of the second range of a batch
        send(16'd1, 16'd4, 1'b0);
        send(16'd11, 16'd22, 1'b1);
        repeat (8) @(negedge clock);
        check("mid_cc_n_lo", cc_n, 10);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("async");
        repeat (3) @(negedge clock);
        check("async_no_total", total_valid, 0);
        release_reset();
        pulses = 0;
        send(16'd1, 16'd1, 1'b1);
        sbq.push_back(16'd3);
        wait_total("post_rst", 0, lat);
        check("post_rst_pulses", pulses, 2);
        check("post_rst_err", err, 0);

`ifdef RANGE_TIMEOUT_EN
        stub_dead = 1'b1;
        send(16'd5, 16'd7, 1'b1);
        sbq.push_back(16'd0);
        wait_total("tmo", 0, lat);
        check("tmo_lat", lat, 18);
        check("tmo_err", err, 1);
        stub_dead = 1'b0;
`endif

        check("sb_drained", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("[TB] %0d tests run, %0d failed", tests, failed + 1);
        $fatal(1, "watchdog");
    end

endmodule
